// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl: memory-mapped LED bank where each channel is off, on, blinking or PWM-dimmed.
// Build option LED_BREATHE_EN adds a global triangular "breathe" duty for PWM channels with bit[2] set.
module led_bank_ctrl #(
  parameter int CHANNELS    = 4,
  parameter int ADDR_W      = 2,
  parameter int PRESCALE    = 1000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                load_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [15:0]         in_i,
  output logic [15:0]         out_o,
  output logic [CHANNELS-1:0] led_o
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BLINK_TICKS - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [1:0]          mode_q [CHANNELS];
  logic [7:0]          duty_q [CHANNELS];
  logic [7:0]          duty_eff [CHANNELS];
  logic [CHANNELS-1:0] wr_en;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [BT_W-1:0]     tcnt_q, tcnt_d;
  logic                blink_q, blink_d;
  logic [7:0]          pwm_q, pwm_d;
  logic                tick;
  logic [CHANNELS-1:0] led_q, led_d;

  // Out-of-range addresses match no channel, so writes to them fall on the floor.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_en[i] = load_i && (addr_i == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en[i]) begin
          mode_q[i] <= in_i[1:0];
          duty_q[i] <= in_i[15:8];
        end
      end
    end
  end

  assign tick = (presc_q == PS_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PS_W'(1);
    tcnt_d  = tcnt_q;
    blink_d = blink_q;
    pwm_d   = pwm_q + 8'd1;
    if (tick) begin
      if (tcnt_q == BT_LAST) begin
        tcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        tcnt_d  = tcnt_q + BT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      blink_q <= 1'b0;
      pwm_q   <= 8'h00;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      blink_q <= blink_d;
      pwm_q   <= pwm_d;
    end
  end

`ifdef LED_BREATHE_EN
  // Breathe direction FSM
  //   state   | meaning
  //   BR_UP   | duty increments on each tick; at 255 turns to 254 and goes down
  //   BR_DOWN | duty decrements on each tick; at 0 turns to 1 and goes up
  typedef enum logic {BR_UP = 1'b0, BR_DOWN = 1'b1} br_dir_e;

  br_dir_e    br_dir_q, br_dir_d;
  logic [7:0] br_duty_q, br_duty_d;
  logic       br_sel_q [CHANNELS];
  logic       unused_in;

  assign unused_in = ^in_i[7:3];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      br_dir_q  <= BR_UP;
      br_duty_q <= 8'h00;
      for (int i = 0; i < CHANNELS; i++) br_sel_q[i] <= 1'b0;
    end else begin
      br_dir_q  <= br_dir_d;
      br_duty_q <= br_duty_d;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en[i]) br_sel_q[i] <= in_i[2];
      end
    end
  end

  always_comb begin
    br_dir_d  = br_dir_q;
    br_duty_d = br_duty_q;
    if (tick) begin
      case (br_dir_q)
        BR_UP: begin
          if (br_duty_q == 8'hFF) begin
            br_dir_d  = BR_DOWN;
            br_duty_d = 8'hFE;
          end else begin
            br_duty_d = br_duty_q + 8'd1;
          end
        end
        BR_DOWN: begin
          if (br_duty_q == 8'h00) begin
            br_dir_d  = BR_UP;
            br_duty_d = 8'h01;
          end else begin
            br_duty_d = br_duty_q - 8'd1;
          end
        end
        default: begin
          br_dir_d  = BR_UP;
          br_duty_d = 8'h00;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_eff[i] = br_sel_q[i] ? br_duty_q : duty_q[i];
    end
  end

  always_comb begin
    out_o = 16'h0000;
    for (int i = 0; i < CHANNELS; i++) begin
      if (addr_i == ADDR_W'(i)) out_o = {duty_q[i], 5'b00000, br_sel_q[i], mode_q[i]};
    end
  end
`else
  logic unused_in;

  assign unused_in = ^in_i[7:2];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_eff[i] = duty_q[i];
    end
  end

  always_comb begin
    out_o = 16'h0000;
    for (int i = 0; i < CHANNELS; i++) begin
      if (addr_i == ADDR_W'(i)) out_o = {duty_q[i], 6'b000000, mode_q[i]};
    end
  end
`endif

  always_comb begin
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_q[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = blink_q;
        MODE_PWM:   led_d[i] = (pwm_q < duty_eff[i]);
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) led_q <= '0;
    else          led_q <= led_d;
  end

  assign led_o = led_q;

endmodule
